dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares one data memory port among num_ports_p cores using the mem_in_s/mem_out_s valid/yumi handshake.
//  Sits between the cores' to_mem_o/from_mem_i/data_mem_addr ports and the single dmem.
//  Round-robin grant; one outstanding access at a time; the granted core's request and address are muxed through.
// PARAMETERS
//  num_ports_p   4   number of requesting cores (>=2)
//  addr_width_p  32  data memory address width
// PORTS
//  clk            in   1                          clock
//  n_reset        in   1                          reset, synchronous, active-low
//  core_req_i     in   mem_in_s [num_ports_p]     per-core request (write_data, valid, wen, byte_not_word, yumi)
//  core_addr_i    in   [num_ports_p][addr_width_p] per-core data_mem_addr
//  core_resp_o    out  mem_out_s [num_ports_p]    per-core response (read_data, valid, yumi)
//  mem_req_o      out  mem_in_s                   to dmem
//  mem_addr_o     out  addr_width_p               to dmem
//  mem_resp_i     in   mem_out_s                  from dmem
//  grant_o        out  num_ports_p                one-hot owner; 0 when idle
//  busy_o         out  1                          state != ARB_IDLE
//  protocol_err_o out  1                          sticky protocol violation flag
// BEHAVIOUR
//  Reset: state=ARB_IDLE, rr pointer=0, grant_r=0, protocol_err_o=0; all outputs 0 (mem_req_o, mem_addr_o, core_resp_o, busy_o).
//  States: ARB_IDLE -> ARB_REQ -> ARB_WAIT -> ARB_IDLE (arb_state_e).
//  ARB_IDLE: if any core_req_i[k].valid, pick first requester at or after the pointer (wrapping);
//   register grant_r one-hot; next=ARB_REQ. Arbitration costs exactly 1 cycle. No request: stay.
//  ARB_REQ: mem_req_o = core_req_i[g] with yumi forced 0; mem_addr_o = core_addr_i[g].
//   mem_resp_i.yumi -> core_resp_o[g].yumi=1 same cycle (combinational); next=ARB_WAIT.
//  ARB_WAIT: mem_req_o.valid=0; write_data/wen/byte_not_word/addr still muxed from g (core holds them).
//  Response in ARB_REQ or ARB_WAIT: core_resp_o[g].valid/read_data = mem_resp_i; mem_req_o.yumi = core_req_i[g].yumi.
//   mem_resp_i.valid & core_req_i[g].yumi -> access complete: next=ARB_IDLE; pointer=(g_index+1) mod num_ports_p; grant_r=0.
//   Complete in ARB_REQ (yumi+valid same cycle, combinational dmem) is legal: ARB_REQ->ARB_IDLE.
//   mem valid without core yumi (core stalled on net write): hold state, keep forwarding until yumi.
//  Non-granted ports: core_resp_o valid=0, yumi=0, read_data=0 always.
//  Fairness: a continuously requesting port waits at most num_ports_p-1 accesses.
//  New request accepted in the cycle after completion (ARB_IDLE); no back-to-back bypass.
//  Protocol errors (set protocol_err_o; cleared only by reset):
//   mem_resp_i.yumi or .valid while ARB_IDLE -> ignored.
//   core_req_i[g].valid drops in ARB_REQ before mem yumi -> abandon; ARB_IDLE, pointer advances.
//  Reset mid-access: synchronous return to reset state; the in-flight dmem transaction is discarded (dmem is reset alongside).
//  Pointer width $clog2(num_ports_p); wrap by explicit compare, not power-of-2 truncation.
// STRUCTURE
//  definitions package: typedef enum logic [1:0] {ARB_IDLE, ARB_REQ, ARB_WAIT} arb_state_e; reuse mem_in_s, mem_out_s.
//  Sub-module rr_picker #(num_ports_p): req vector + pointer -> one-hot grant + index, purely combinational.
//  Top: state/pointer/grant registers, request/response muxes, error flag.
// TESTING
//  1 Reset; core1 valid, dmem yumi 2 cycles later, valid 3 cycles later -> grant_o=0010 cycle+1; core1 yumi/valid mirrored; others 0.
//  2 Cores 0 and 2 request together at reset pointer -> core0 served, then core2; grant_o 0001 then 0100.
//  3 All 4 hold valid for 8 accesses -> service order 0,1,2,3,0,1,2,3; each waits <=3 accesses.
//  4 Dmem asserts yumi and valid with read_data=32'hDEADBEEF in first ARB_REQ cycle; core yumi -> core gets data; ARB_IDLE next cycle.
//  5 Dmem valid while core yumi held 0 for 3 cycles -> state holds ARB_WAIT, read_data stable, completes on yumi.
//  6 n_reset low during ARB_WAIT -> next cycle all outputs 0, pointer 0; dmem valid while idle -> protocol_err_o=1.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: the core/dmem handshake structs
// and the arbiter state encoding.
package dmem_arbiter_pkg;

  localparam int data_width_lp = 32;

  // Request travelling toward the data memory (a core's to_mem_o)
  typedef struct packed {
    logic [data_width_lp-1:0] write_data;
    logic                     valid;
    logic                     wen;
    logic                     byte_not_word;
    logic                     yumi;
  } mem_in_s;

  // Response travelling back from the data memory (a core's from_mem_i)
  typedef struct packed {
    logic [data_width_lp-1:0] read_data;
    logic                     valid;
    logic                     yumi;
  } mem_out_s;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_REQ,
    ARB_WAIT
  } arb_state_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundles the per-core ports, the single dmem port and the arbiter status
// outputs. The arbiter uses the slave modport; whoever drives cores and dmem
// uses the master modport.
interface dmem_arbiter_if #(
  parameter int num_ports_p  = 4,
  parameter int addr_width_p = 32
);
  import dmem_arbiter_pkg::*;

  mem_in_s  [num_ports_p-1:0]                    core_req_i;
  logic     [num_ports_p-1:0][addr_width_p-1:0]  core_addr_i;
  mem_out_s [num_ports_p-1:0]                    core_resp_o;
  mem_in_s                                       mem_req_o;
  logic     [addr_width_p-1:0]                   mem_addr_o;
  mem_out_s                                      mem_resp_i;
  logic     [num_ports_p-1:0]                    grant_o;
  logic                                          busy_o;
  logic                                          protocol_err_o;

  modport slave (
    input  core_req_i, core_addr_i, mem_resp_i,
    output core_resp_o, mem_req_o, mem_addr_o, grant_o, busy_o, protocol_err_o
  );

  modport master (
    output core_req_i, core_addr_i, mem_resp_i,
    input  core_resp_o, mem_req_o, mem_addr_o, grant_o, busy_o, protocol_err_o
  );

endinterface

// File: rtl/dmem_arbiter_rr_picker.sv
// Round-robin picker: scans the request vector starting at the pointer and
// wrapping around, returning the first requester as one-hot and as an index.
module rr_picker #(
  parameter  int num_ports_p  = 4,
  localparam int ptr_width_lp = $clog2(num_ports_p)
) (
  input  logic [num_ports_p-1:0]  req,
  input  logic [ptr_width_lp-1:0] ptr,
  output logic [num_ports_p-1:0]  grant,
  output logic [ptr_width_lp-1:0] idx,
  output logic                    found
);

  // Walk offsets 0..N-1 from the pointer; the wrap uses an explicit compare
  // so non-power-of-two port counts never select a nonexistent port.
  always_comb begin
    logic [ptr_width_lp:0] cand;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int off = 0; off < num_ports_p; off++) begin
      cand = {1'b0, ptr} + (ptr_width_lp+1)'(off);
      if (cand >= (ptr_width_lp+1)'(num_ports_p)) begin
        cand = cand - (ptr_width_lp+1)'(num_ports_p);
      end
      if (!found && req[cand[ptr_width_lp-1:0]]) begin
        found                          = 1'b1;
        grant[cand[ptr_width_lp-1:0]]  = 1'b1;
        idx                            = cand[ptr_width_lp-1:0];
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data-memory port among several cores. One access is in flight
// at a time; the owner is chosen round-robin and its request/address are
// muxed to dmem while the dmem response is steered back to it alone.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int num_ports_p  = 4,
  parameter int addr_width_p = 32
) (
  input  logic            clk,
  input  logic            n_reset,
  dmem_arbiter_if.slave   bus
);

  localparam int ptr_width_lp = $clog2(num_ports_p);

  arb_state_e                state_r, state_n;
  logic [ptr_width_lp-1:0]   ptr_r, ptr_n;
  logic [num_ports_p-1:0]    grant_r, grant_n;
  logic [ptr_width_lp-1:0]   idx_r, idx_n;
  logic                      err_r, err_n;

  logic [num_ports_p-1:0]    req_valid;
  logic [num_ports_p-1:0]    pick_grant;
  logic [ptr_width_lp-1:0]   pick_idx;
  logic                      pick_found;

  mem_in_s                   sel_req;
  logic [addr_width_p-1:0]   sel_addr;
  logic                      complete;
  logic [ptr_width_lp-1:0]   ptr_after_owner;

  mem_in_s                   mem_req;
  logic [addr_width_p-1:0]   mem_addr;
  mem_out_s [num_ports_p-1:0] core_resp;

  // Collect each core's valid bit into a vector for the picker
  always_comb begin
    req_valid = '0;
    for (int k = 0; k < num_ports_p; k++) begin
      req_valid[k] = bus.core_req_i[k].valid;
    end
  end

  rr_picker #(.num_ports_p(num_ports_p)) picker (
    .req   (req_valid),
    .ptr   (ptr_r),
    .grant (pick_grant),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign sel_req  = bus.core_req_i[idx_r];
  assign sel_addr = bus.core_addr_i[idx_r];

  // An access finishes once dmem has data and the owning core consumes it
  assign complete = bus.mem_resp_i.valid & sel_req.yumi;

  // The next search starts just after the current owner, wrapping at the last port
  assign ptr_after_owner = (idx_r == ptr_width_lp'(num_ports_p - 1)) ? '0 : idx_r + 1'b1;

  // State, pointer, grant and sticky error registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_r <= ARB_IDLE;
      ptr_r   <= '0;
      grant_r <= '0;
      idx_r   <= '0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_n;
      ptr_r   <= ptr_n;
      grant_r <= grant_n;
      idx_r   <= idx_n;
      err_r   <= err_n;
    end
  end

  // Next-state: arbitrate when idle, track dmem acceptance, release on completion or abandon
  always_comb begin
    state_n = state_r;
    ptr_n   = ptr_r;
    grant_n = grant_r;
    idx_n   = idx_r;
    err_n   = err_r;
    case (state_r)
      ARB_IDLE: begin
        if (bus.mem_resp_i.valid || bus.mem_resp_i.yumi) begin
          err_n = 1'b1;
        end
        if (pick_found) begin
          grant_n = pick_grant;
          idx_n   = pick_idx;
          state_n = ARB_REQ;
        end
      end
      ARB_REQ: begin
        if (complete) begin
          state_n = ARB_IDLE;
          grant_n = '0;
          ptr_n   = ptr_after_owner;
        end else if (!sel_req.valid) begin
          state_n = ARB_IDLE;
          grant_n = '0;
          ptr_n   = ptr_after_owner;
          err_n   = 1'b1;
        end else if (bus.mem_resp_i.yumi) begin
          state_n = ARB_WAIT;
        end
      end
      ARB_WAIT: begin
        if (complete) begin
          state_n = ARB_IDLE;
          grant_n = '0;
          ptr_n   = ptr_after_owner;
        end
      end
      default: begin
        state_n = ARB_IDLE;
        grant_n = '0;
      end
    endcase
  end

  // Datapath muxing: owner's request/address to dmem, dmem response to owner only
  always_comb begin
    mem_req   = '0;
    mem_addr  = '0;
    core_resp = '0;
    if (state_r != ARB_IDLE) begin
      mem_req      = sel_req;
      mem_req.yumi = sel_req.yumi & bus.mem_resp_i.valid;
      if (state_r == ARB_WAIT) begin
        mem_req.valid = 1'b0;
      end
      mem_addr = sel_addr;
      for (int k = 0; k < num_ports_p; k++) begin
        if (grant_r[k]) begin
          core_resp[k].read_data = bus.mem_resp_i.read_data;
          core_resp[k].valid     = bus.mem_resp_i.valid;
          core_resp[k].yumi      = (state_r == ARB_REQ) & bus.mem_resp_i.yumi;
        end
      end
    end
  end

  assign bus.mem_req_o      = mem_req;
  assign bus.mem_addr_o     = mem_addr;
  assign bus.core_resp_o    = core_resp;
  assign bus.grant_o        = grant_r;
  assign bus.busy_o         = (state_r != ARB_IDLE);
  assign bus.protocol_err_o = err_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a transaction-level reference model (owner index,
// accepted flag, round-robin pointer, error flag) predicts every output each
// cycle while a driver plays the cores and dmem with directed and random timing.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  localparam int num_ports_lp = 4;
  localparam int addr_width_lp = 32;

  logic clk;
  logic n_reset;

  dmem_arbiter_if #(.num_ports_p(num_ports_lp), .addr_width_p(addr_width_lp)) bus ();

  dmem_arbiter #(.num_ports_p(num_ports_lp), .addr_width_p(addr_width_lp)) dut (
    .clk     (clk),
    .n_reset (n_reset),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vec_count = 0;
  int err_count = 0;

  // reference model state
  int          m_owner = -1;
  bit          m_accepted = 1'b0;
  int          m_ptr = 0;
  bit          m_err = 1'b0;
  int          done_q[$];
  logic [31:0] got_rd;

  // driver configuration and progress
  bit [3:0]    want_mask;
  bit          one_shot;
  bit          rand_mode;
  bit          fixed_rd_en;
  int          yumi_dly, valid_dly, stall_dly;
  int          cnt, stall_cnt;
  logic [31:0] rd_value;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    vec_count++;
    if (actual !== expected) begin
      err_count++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic clearInputs();
    bus.core_req_i  = '0;
    bus.core_addr_i = '0;
    bus.mem_resp_i  = '0;
  endtask

  // Compare all outputs against the model, advance the model, then step one clock
  task automatic applyStimulus();
    logic [3:0] exp_grant;
    mem_in_s    exp_req;
    mem_in_s    r;
    logic [31:0] exp_addr;
    mem_out_s   exp_resp;
    #1;
    exp_grant = (m_owner < 0) ? 4'b0 : 4'(1 << m_owner);
    exp_req   = '0;
    exp_addr  = '0;
    if (m_owner >= 0) begin
      r             = bus.core_req_i[m_owner];
      exp_req       = r;
      exp_req.valid = r.valid && !m_accepted;
      exp_req.yumi  = r.yumi && bus.mem_resp_i.valid;
      exp_addr      = bus.core_addr_i[m_owner];
    end
    checkOutput("grant", 64'(bus.grant_o), 64'(exp_grant));
    checkOutput("busy", 64'(bus.busy_o), 64'(m_owner >= 0));
    checkOutput("protocol_err", 64'(bus.protocol_err_o), 64'(m_err));
    checkOutput("mem_req", 64'(bus.mem_req_o), 64'(exp_req));
    checkOutput("mem_addr", 64'(bus.mem_addr_o), 64'(exp_addr));
    for (int k = 0; k < num_ports_lp; k++) begin
      exp_resp = '0;
      if (k == m_owner) begin
        exp_resp.read_data = bus.mem_resp_i.read_data;
        exp_resp.valid     = bus.mem_resp_i.valid;
        exp_resp.yumi      = bus.mem_resp_i.yumi && !m_accepted;
      end
      checkOutput($sformatf("core_resp%0d", k), 64'(bus.core_resp_o[k]), 64'(exp_resp));
    end
    if (!n_reset) begin
      m_owner = -1; m_accepted = 1'b0; m_ptr = 0; m_err = 1'b0;
    end else if (m_owner < 0) begin
      if (bus.mem_resp_i.valid || bus.mem_resp_i.yumi) m_err = 1'b1;
      for (int off = 0; off < num_ports_lp; off++) begin
        int k;
        k = (m_ptr + off) % num_ports_lp;
        if (m_owner < 0 && bus.core_req_i[k].valid) m_owner = k;
      end
      m_accepted = 1'b0;
    end else begin
      r = bus.core_req_i[m_owner];
      if (bus.mem_resp_i.valid && r.yumi) begin
        got_rd = bus.core_resp_o[m_owner].read_data;
        done_q.push_back(m_owner);
        m_ptr = (m_owner + 1) % num_ports_lp;
        m_owner = -1;
        m_accepted = 1'b0;
      end else if (!m_accepted && !r.valid) begin
        m_err = 1'b1;
        m_ptr = (m_owner + 1) % num_ports_lp;
        m_owner = -1;
      end else if (!m_accepted && bus.mem_resp_i.yumi) begin
        m_accepted = 1'b1;
      end
    end
    @(posedge clk);
    #2;
  endtask

  // Play cores and dmem for one cycle according to the current configuration
  task automatic driveCycle();
    int  prev_owner;
    bit  take;
    bit  abandon;
    bit  saw_valid;
    abandon = 1'b0;
    for (int k = 0; k < num_ports_lp; k++) begin
      bus.core_req_i[k].write_data    = $urandom;
      bus.core_req_i[k].wen           = 1'($urandom_range(0, 1));
      bus.core_req_i[k].byte_not_word = 1'($urandom_range(0, 1));
      bus.core_req_i[k].yumi          = 1'b0;
      bus.core_addr_i[k]              = $urandom;
      if (rand_mode) bus.core_req_i[k].valid = (k == m_owner) ? 1'b1 : 1'($urandom_range(0, 1));
      else           bus.core_req_i[k].valid = want_mask[k];
    end
    if (rand_mode && m_owner >= 0 && !m_accepted && $urandom_range(0, 19) == 0) begin
      abandon = 1'b1;
      bus.core_req_i[m_owner].valid = 1'b0;
    end
    bus.mem_resp_i = '0;
    take = 1'b0;
    if (m_owner >= 0) begin
      take = !m_accepted && cnt >= yumi_dly && !abandon;
      bus.mem_resp_i.yumi = take;
      if ((m_accepted || take) && cnt >= valid_dly) begin
        bus.mem_resp_i.valid     = 1'b1;
        bus.mem_resp_i.read_data = rd_value;
      end
      if (bus.mem_resp_i.valid && stall_cnt >= stall_dly) bus.core_req_i[m_owner].yumi = 1'b1;
      if (take && one_shot) want_mask[m_owner] = 1'b0;
    end
    prev_owner = m_owner;
    saw_valid  = bus.mem_resp_i.valid;
    applyStimulus();
    if (prev_owner < 0 && m_owner >= 0) begin
      cnt = 0;
      stall_cnt = 0;
      rd_value = fixed_rd_en ? 32'hDEADBEEF : $urandom;
      if (rand_mode) begin
        yumi_dly  = $urandom_range(0, 3);
        valid_dly = yumi_dly + int'($urandom_range(0, 3));
        stall_dly = $urandom_range(0, 2);
      end
    end else begin
      cnt++;
      if (saw_valid) stall_cnt++;
    end
  endtask

  // Run until target completions (or for budget cycles when target < 0)
  task automatic runCycles(input int budget, input int target);
    int n;
    n = 0;
    while (n < budget && (target < 0 || done_q.size() < target)) begin
      driveCycle();
      n++;
    end
    if (target >= 0 && done_q.size() < target) checkOutput("timeout", 64'(done_q.size()), 64'(target));
  endtask

  task automatic doReset();
    clearInputs();
    n_reset = 1'b0;
    applyStimulus();
    n_reset = 1'b1;
    done_q.delete();
    cnt = 0; stall_cnt = 0;
    want_mask = '0; one_shot = 1'b1; rand_mode = 1'b0; fixed_rd_en = 1'b0;
  endtask

  task automatic configure(input bit [3:0] mask, input bit shot, input int y, input int v, input int s);
    want_mask = mask; one_shot = shot; yumi_dly = y; valid_dly = v; stall_dly = s;
  endtask

  initial begin
    clearInputs();
    n_reset = 1'b0;
    @(posedge clk);
    #2;
    doReset();

    // single request from core 1, dmem yumi 2 cycles and valid 3 cycles after the request
    configure(4'b0010, 1'b1, 1, 2, 0);
    runCycles(20, 1);
    checkOutput("t1_owner", 64'(done_q[0]), 64'd1);
    runCycles(2, -1);

    // cores 0 and 2 together from the reset pointer
    doReset();
    configure(4'b0101, 1'b1, 1, 1, 0);
    runCycles(40, 2);
    checkOutput("t2_first", 64'(done_q[0]), 64'd0);
    checkOutput("t2_second", 64'(done_q[1]), 64'd2);

    // all four cores requesting continuously
    doReset();
    configure(4'b1111, 1'b0, 0, 1, 0);
    runCycles(100, 8);
    for (int i = 0; i < 8; i++) begin
      int gap;
      checkOutput($sformatf("t3_order%0d", i), 64'(done_q[i]), 64'(i % 4));
      gap = 0;
      for (int j = i - 1; j >= 0 && done_q[j] != done_q[i]; j--) gap++;
      if (i >= 4) checkOutput($sformatf("t3_wait%0d", i), 64'(gap <= 3), 64'd1);
    end

    // combinational dmem completes in the first request cycle
    doReset();
    configure(4'b0100, 1'b1, 0, 0, 0);
    fixed_rd_en = 1'b1;
    runCycles(10, 1);
    checkOutput("t4_data", 64'(got_rd), 64'hDEADBEEF);
    runCycles(2, -1);

    // core stalls on the response for 3 cycles
    doReset();
    configure(4'b1000, 1'b1, 0, 1, 3);
    runCycles(20, 1);
    checkOutput("t5_owner", 64'(done_q[0]), 64'd3);

    // randomized traffic including occasional abandoned requests
    doReset();
    rand_mode = 1'b1;
    one_shot = 1'b0;
    yumi_dly = 1; valid_dly = 2; stall_dly = 0;
    runCycles(400, -1);
    checkOutput("rand_progress", 64'(done_q.size() > 10), 64'd1);

    // reset in the middle of an access, then dmem response while idle
    doReset();
    configure(4'b0100, 1'b1, 0, 10, 0);
    runCycles(3, -1);
    checkOutput("t6_in_wait", 64'(bus.busy_o), 64'd1);
    clearInputs();
    n_reset = 1'b0;
    applyStimulus();
    n_reset = 1'b1;
    checkOutput("t6_busy", 64'(bus.busy_o), 64'd0);
    checkOutput("t6_grant", 64'(bus.grant_o), 64'd0);
    bus.mem_resp_i.valid = 1'b1;
    applyStimulus();
    clearInputs();
    checkOutput("t6_err", 64'(bus.protocol_err_o), 64'd1);
    done_q.delete();
    cnt = 0; stall_cnt = 0;
    configure(4'b1111, 1'b1, 0, 0, 0);
    runCycles(20, 1);
    checkOutput("t6_ptr", 64'(done_q[0]), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
